yj_fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single write port of a yj FIFO between

---
 rtl/yj_fifo_wr_arbiter_if.sv | 27 ++
 rtl/yj_fifo_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_yj_fifo_wr_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/yj_fifo_wr_arbiter_if.sv
// Requester and FIFO write-side signals of the yj FIFO write arbiter.
// master = requesters plus FIFO status, slave = the arbiter itself.
interface yj_fifo_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int GW   = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_last;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               fifo_full;
    logic               fifo_wr_en;
    logic [DW-1:0]      fifo_wr_data;
    logic [GW-1:0]      grant_id;
    logic               busy;

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );
endinterface

// File: rtl/yj_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one yj FIFO write port between NREQ requesters.
// Bursts are granted one at a time, with a single IDLE bubble between grants.

// Per-requester handshake: ready only for the granted lane, data masked to 0 unless transferring.
module yj_fifo_wr_arb_lane #(
    parameter int DW = 32
) (
    input  logic          sel,
    input  logic          fifo_full,
    input  logic          valid,
    input  logic [DW-1:0] data,
    output logic          ready,
    output logic          xfer,
    output logic [DW-1:0] data_out
);
    assign ready    = sel & ~fifo_full;
    assign xfer     = ready & valid;
    assign data_out = xfer ? data : '0;
endmodule

module yj_fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 32,
    parameter int BURST_MAX = 4
) (
    input logic                 CLK,
    input logic                 RSTn,
    yj_fifo_wr_arbiter_if.slave bus
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_MAX - 1);
    localparam logic [GW-1:0] PTR_MAX   = GW'(NREQ - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                   state, state_nxt;
    logic [GW-1:0]            rr_ptr, rr_ptr_nxt;
    logic [GW-1:0]            grant_id, grant_nxt;
    logic [CW-1:0]            beat_cnt, beat_cnt_nxt;
    logic [GW-1:0]            winner;
    logic                     found;
    logic                     busy;
    logic                     xfer;
    logic                     burst_end;
    logic [NREQ-1:0]          sel;
    logic [NREQ-1:0]          ready;
    logic [NREQ-1:0]          lane_xfer;
    logic [NREQ-1:0][DW-1:0]  lane_data;
    logic [DW-1:0]            wr_data;

    assign busy = (state == BURST);

    genvar i;
    generate
        for (i = 0; i < NREQ; i++) begin : g_lane
            assign sel[i] = busy && (grant_id == GW'(i));
            yj_fifo_wr_arb_lane #(.DW(DW)) u_lane (
                .sel      (sel[i]),
                .fifo_full(bus.fifo_full),
                .valid    (bus.req_valid[i]),
                .data     (bus.req_data[i*DW +: DW]),
                .ready    (ready[i]),
                .xfer     (lane_xfer[i]),
                .data_out (lane_data[i])
            );
        end
    endgenerate

    // Only the granted lane can transfer, so OR-ing the masked lanes is a mux.
    always_comb begin
        wr_data = '0;
        for (int k = 0; k < NREQ; k++) wr_data |= lane_data[k];
    end

    assign xfer      = |lane_xfer;
    assign burst_end = xfer & (bus.req_last[grant_id] | (beat_cnt == LAST_BEAT));

    // First valid requester at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        logic [GW:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr} + (GW+1)'(k);
            if (idx >= (GW+1)'(NREQ)) idx = idx - (GW+1)'(NREQ);
            if (!found && bus.req_valid[idx[GW-1:0]]) begin
                winner = idx[GW-1:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        grant_nxt    = grant_id;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt    = winner;
                    beat_cnt_nxt = '0;
                    state_nxt    = BURST;
                end
            end
            BURST: begin
                if (burst_end) begin
                    state_nxt    = IDLE;
                    rr_ptr_nxt   = (grant_id == PTR_MAX) ? '0 : grant_id + 1'b1;
                    beat_cnt_nxt = '0;
                end else if (xfer) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant_id <= grant_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    assign bus.req_ready    = ready;
    assign bus.fifo_wr_en   = xfer;
    assign bus.fifo_wr_data = wr_data;
    assign bus.grant_id     = grant_id;
    assign bus.busy         = busy;
endmodule

// File: tb/tb_yj_fifo_wr_arbiter.sv
// Bench for yj_fifo_wr_arbiter: requester queues drive beats, a scoreboard holds
// the hand-ordered expected writes and a negedge monitor checks every FIFO write.
module tb_yj_fifo_wr_arbiter;
    localparam int NREQ      = 4;
    localparam int DW        = 32;
    localparam int BURST_MAX = 4;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    yj_fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    yj_fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus)
    );

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            gap;   // cycles since previous write, 0 = don't care
    } exp_t;

    exp_t          sbq[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            last_wr_cyc = 0;
    logic [DW:0]   beats [NREQ][64];
    int            head [NREQ] = '{default: 0};
    int            tail [NREQ] = '{default: 0};

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [DW-1:0] dv(input int id, input int b);
        return DW'(32'hA500_0000 + id * 256 + b);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // mode 0: every beat last, 1: last on final beat only
    task automatic load(input int id, input int b0, input int nb, input int mode);
        for (int b = 0; b < nb; b++) begin
            beats[id][tail[id]] = {(mode == 0) || (b == nb - 1), dv(id, b0 + b)};
            tail[id]++;
        end
    endtask

    task automatic expect_wr(input int id, input int b, input int gap);
        exp_t e;
        e.id = id; e.data = dv(id, b); e.gap = gap;
        sbq.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge CLK);
            n++;
        end
        if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 0);
    endtask

    task automatic wait_write(input logic [DW-1:0] d);
        int n = 0;
        @(negedge CLK);
        while (!(bus.fifo_wr_en && bus.fifo_wr_data == d) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) chk("wait_write_timeout", 1, 0);
    endtask

    // Requester model: present the queue head after each rising edge.
    initial begin
        logic [NREQ-1:0]    v, l;
        logic [NREQ*DW-1:0] d;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        forever begin
            @(posedge CLK);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (head[i] < tail[i]) begin
                    v[i]          = 1'b1;
                    l[i]          = beats[i][head[i]][DW];
                    d[i*DW +: DW] = beats[i][head[i]][DW-1:0];
                end else begin
                    v[i]          = 1'b0;
                    l[i]          = 1'($urandom_range(0, 1));
                    d[i*DW +: DW] = $urandom;
                end
            end
            bus.req_valid = v;
            bus.req_last  = l;
            bus.req_data  = d;
        end
    end

    // Monitor: handshake invariants every cycle, scoreboard compare on each write.
    initial begin
        logic [NREQ-1:0] acc;
        exp_t e;
        forever begin
            @(negedge CLK);
            acc = bus.req_valid & bus.req_ready;
            chk("ready_onehot", 64'($countones(bus.req_ready) <= 1), 1);
            if (bus.req_ready != '0) chk("ready_to_grant", 64'(bus.req_ready), 64'(1 << bus.grant_id));
            if (bus.fifo_full) chk("ready_when_full", 64'(bus.req_ready), 0);
            chk("wr_en_vs_handshake", 64'(bus.fifo_wr_en), 64'(|acc));
            if (!bus.fifo_wr_en) chk("idle_data_zero", 64'(bus.fifo_wr_data), 0);
            if (bus.fifo_wr_en) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_write", 64'(bus.fifo_wr_data), 0);
                end else begin
                    e = sbq.pop_front();
                    chk("wr_grant_id", 64'(bus.grant_id), 64'(e.id));
                    chk("wr_data", 64'(bus.fifo_wr_data), 64'(e.data));
                    chk("wr_busy", 64'(bus.busy), 1);
                    if (e.gap != 0) chk("wr_gap", 64'(cyc - last_wr_cyc), 64'(e.gap));
                end
                last_wr_cyc = cyc;
            end
            for (int i = 0; i < NREQ; i++) if (acc[i]) head[i]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.fifo_full = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_ready", 64'(bus.req_ready), 0);
        chk("rst_wr_en", 64'(bus.fifo_wr_en), 0);
        chk("rst_wr_data", 64'(bus.fifo_wr_data), 0);
        chk("rst_grant_id", 64'(bus.grant_id), 0);
        #2 RSTn = 1'b1;

        // 1: lone requester 2, 3-beat burst, one cycle arbitration latency.
        load(2, 0, 3, 1);
        expect_wr(2, 0, 0); expect_wr(2, 1, 1); expect_wr(2, 2, 1);
        n = 0;
        @(negedge CLK);
        while (!bus.req_valid[2] && n < 20) begin @(negedge CLK); n++; end
        chk("t1_idle_busy", 64'(bus.busy), 0);
        chk("t1_idle_wr_en", 64'(bus.fifo_wr_en), 0);
        @(negedge CLK);
        chk("t1_first_busy", 64'(bus.busy), 1);
        chk("t1_first_ready", 64'(bus.req_ready), 64'(4'b0100));
        chk("t1_first_wr_en", 64'(bus.fifo_wr_en), 1);
        drain();
        @(negedge CLK);
        chk("t1_busy_after", 64'(bus.busy), 0);
        chk("t1_grant_held", 64'(bus.grant_id), 2);

        // 6: rr_ptr is now 3, so requester 3 beats requester 0 and then wraps.
        load(0, 0, 1, 0); load(3, 0, 1, 0);
        expect_wr(3, 0, 0); expect_wr(0, 0, 2);
        drain();

        // 2: all four pending from rr_ptr 0, single-beat bursts.
        @(negedge CLK); RSTn = 1'b0;
        @(negedge CLK); RSTn = 1'b1;
        load(0, 10, 2, 0); load(1, 10, 1, 0); load(2, 10, 1, 0); load(3, 10, 1, 0);
        expect_wr(0, 10, 0); expect_wr(1, 10, 2); expect_wr(2, 10, 2);
        expect_wr(3, 10, 2); expect_wr(0, 11, 2);
        drain();

        // 3: requester 1 never ends its burst early; forced back after 4 beats.
        load(1, 20, 6, 1); load(2, 20, 1, 0);
        expect_wr(1, 20, 0); expect_wr(1, 21, 1); expect_wr(1, 22, 1); expect_wr(1, 23, 1);
        expect_wr(2, 20, 2); expect_wr(1, 24, 2); expect_wr(1, 25, 1);
        drain();

        // 4: FIFO full for 5 cycles after the second beat.
        load(3, 30, 4, 1);
        expect_wr(3, 30, 0); expect_wr(3, 31, 1); expect_wr(3, 32, 6); expect_wr(3, 33, 1);
        wait_write(dv(3, 31));
        @(posedge CLK); #1 bus.fifo_full = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            chk("t4_full_wr_en", 64'(bus.fifo_wr_en), 0);
            chk("t4_full_busy", 64'(bus.busy), 1);
            chk("t4_full_grant", 64'(bus.grant_id), 3);
        end
        @(posedge CLK); #1 bus.fifo_full = 1'b0;
        drain();

        // 5: reset after two beats of a burst; requester 0 wins afterwards.
        load(2, 40, 4, 1);
        expect_wr(2, 40, 0); expect_wr(2, 41, 1); expect_wr(0, 40, 0);
        expect_wr(2, 42, 2); expect_wr(2, 43, 1);
        wait_write(dv(2, 41));
        @(posedge CLK); #2 RSTn = 1'b0;
        #1;
        chk("t5_rst_busy", 64'(bus.busy), 0);
        chk("t5_rst_ready", 64'(bus.req_ready), 0);
        chk("t5_rst_wr_en", 64'(bus.fifo_wr_en), 0);
        chk("t5_rst_wr_data", 64'(bus.fifo_wr_data), 0);
        chk("t5_rst_grant", 64'(bus.grant_id), 0);
        load(0, 40, 1, 0);
        @(posedge CLK);
        @(negedge CLK); #2 RSTn = 1'b1;
        drain();
        repeat (3) @(posedge CLK);
        chk("sb_empty", 64'(sbq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
